// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame parser: sync marker, FSM
// encoding, ALU opcodes and header field positions.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HDR,
    ST_OPA,
    ST_OPB,
    ST_CSUM
  } state_t;

  // Opcode values understood by the downstream ALU/SWITCH path
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int HDR_OP_LSB = 0;
  localparam int HDR_OP_W   = 3;
  localparam int HDR_CH_LSB = 3;

  function automatic logic [HDR_OP_W-1:0] hdr_opcode(input logic [7:0] hdr);
    return hdr[HDR_OP_LSB +: HDR_OP_W];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for parsed commands; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// Hunts for SYNC, parses HDR/A/B/CSUM frames and queues good commands.
// Optional inter-byte timeout: define UART_CMD_FRAME_PARSER_TIMEOUT_EN.
module uart_cmd_frame_parser
  import uart_cmd_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         CH_W        = 2,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [2:0]                    cmd_opcode,
  output logic [((CH_W > 0) ? CH_W : 1)-1:0] cmd_ch,
  output logic [DATA_W-1:0]             cmd_a,
  output logic [DATA_W-1:0]             cmd_b,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
  output logic                          err_csum,
  output logic                          err_ovf,
  output logic                          err_timeout,
  output logic [7:0]                    err_total
);

  localparam int NB  = DATA_W / 8;
  localparam int CHS = (CH_W > 0) ? CH_W : 1;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int FW  = 3 + CHS + 2 * DATA_W;

  state_t            state;
  logic [2:0]        op_q;
  logic [CHS-1:0]    ch_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [7:0]        xor_q;
  logic [BCW-1:0]    bcnt;

  logic [CHS-1:0]    hdr_ch;
  logic              csum_byte;
  logic              csum_hit;
  logic              ovf_hit;
  logic              timeout_hit;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic              last_byte;

  assign hdr_ch    = (CH_W > 0) ? rx_data[HDR_CH_LSB +: CHS] : '0;
  assign last_byte = (bcnt == BCW'(NB - 1));
  assign csum_byte = rx_valid && (state == ST_CSUM);
  assign fifo_push = csum_byte && (rx_data == xor_q);
  assign csum_hit  = csum_byte && (rx_data != xor_q);
  assign fifo_pop  = cmd_valid && cmd_ready;
  assign ovf_hit   = fifo_push && fifo_full && !fifo_pop;

`ifdef UART_CMD_FRAME_PARSER_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Idle counter only runs mid-frame; any received byte restarts it
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                              to_cnt <= '0;
    else if (rx_valid || state == ST_HUNT)   to_cnt <= '0;
    else                                     to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state != ST_HUNT) && !rx_valid &&
                       (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
`endif

  // Frame FSM plus registered error pulses; a SYNC inside a frame is plain data
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      op_q        <= '0;
      ch_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      xor_q       <= '0;
      bcnt        <= '0;
      err_csum    <= 1'b0;
      err_ovf     <= 1'b0;
      err_timeout <= 1'b0;
      err_total   <= '0;
    end else begin
      err_csum    <= csum_hit;
      err_ovf     <= ovf_hit;
      err_timeout <= timeout_hit;
      if ((csum_hit || ovf_hit || timeout_hit) && err_total != 8'hFF)
        err_total <= err_total + 1'b1;
      if (rx_valid) begin
        unique case (state)
          ST_HUNT: if (rx_data == SYNC_BYTE) state <= ST_HDR;
          ST_HDR: begin
            op_q  <= hdr_opcode(rx_data);
            ch_q  <= hdr_ch;
            xor_q <= rx_data;
            bcnt  <= '0;
            state <= ST_OPA;
          end
          ST_OPA: begin
            a_q   <= (a_q << 8) | DATA_W'(rx_data);
            xor_q <= xor_q ^ rx_data;
            bcnt  <= last_byte ? '0 : bcnt + 1'b1;
            if (last_byte) state <= ST_OPB;
          end
          ST_OPB: begin
            b_q   <= (b_q << 8) | DATA_W'(rx_data);
            xor_q <= xor_q ^ rx_data;
            bcnt  <= last_byte ? '0 : bcnt + 1'b1;
            if (last_byte) state <= ST_CSUM;
          end
          ST_CSUM: state <= ST_HUNT;
          default: state <= ST_HUNT;
        endcase
      end else if (timeout_hit) begin
        state <= ST_HUNT;
      end
    end
  end

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({op_q, ch_q, a_q, b_q}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  assign cmd_valid  = !fifo_empty;
  assign cmd_opcode = fifo_rdata[FW-1 -: 3];
  assign cmd_ch     = fifo_rdata[2*DATA_W +: CHS];
  assign cmd_a      = fifo_rdata[DATA_W +: DATA_W];
  assign cmd_b      = fifo_rdata[0 +: DATA_W];

endmodule

// File: doc/uart_cmd_frame_parser.md
Name: uart_cmd_frame_parser

Overview:
Parametrised successor to the fixed 8-bit UART command parser. Consumes bytes from UART_RX and hunts for a sync byte. Parses a framed, checksummed command carrying opcode, channel and two DATA_W-bit operands. Buffers validated commands in a small FIFO and presents them to the SWITCH/ALU/FSM path through a valid/ready handshake.

Parameters:
DATA_W, 8, operand width in bits; multiple of 8, range 8..32; NB = DATA_W/8 bytes per operand
CH_W, 2, channel field width in bits; range 0..5
FIFO_DEPTH, 4, command buffer entries; power of 2, at least 2
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 100000, inter-byte timeout in clock cycles; used only with the optional feature

Ports:
clock  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  byte from UART_RX
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
cmd_valid  out  1  FIFO head holds a command
cmd_ready  in  1  consumer accepts the head when cmd_valid & cmd_ready
cmd_opcode  out  3  head opcode
cmd_ch  out  max(CH_W,1)  head channel; 0 when CH_W=0
cmd_a  out  DATA_W  head operand A
cmd_b  out  DATA_W  head operand B
cmd_count  out  $clog2(FIFO_DEPTH)+1  number of entries held
err_csum  out  1  one-cycle pulse: checksum mismatch, frame dropped
err_ovf  out  1  one-cycle pulse: valid frame dropped because FIFO full
err_timeout  out  1  one-cycle pulse: frame aborted by timeout
err_total  out  8  saturating count of all error pulses

Behaviour:
- Reset: the asynchronous assert of rst_n forces the following, from any state including mid-frame:
  - FSM to HUNT
  - FIFO emptied
  - cmd_valid=0, cmd_count=0, all err_* = 0, err_total=0, cmd_a/b/opcode/ch = 0
  - partial frame discarded
- Frame byte order: SYNC, HDR, A (NB bytes, MSB first), B (NB bytes, MSB first), CSUM.
  - HDR[2:0] = opcode.
  - HDR[3+CH_W-1:3] = channel.
  - Remaining HDR bits are ignored but included in the checksum.
  - CSUM = XOR of HDR and all A and B bytes. SYNC is excluded.
- FSM states: HUNT, HDR, OPA, OPB, CSUM. It advances only on rx_valid.
  - HUNT: SYNC_BYTE -> HDR; any other byte is discarded silently.
  - HDR: latch header, seed running XOR -> OPA.
  - OPA: shift byte into A, byte counter 0..NB-1; last byte -> OPB, counter cleared.
  - OPB: same as OPA for B; last byte -> CSUM.
  - CSUM: on match push into FIFO; on mismatch pulse err_csum. Then -> HUNT.
  - SYNC_BYTE received inside a frame is treated as data. There is no resync.
- Push timing:
  - The push is registered. cmd_valid rises in the cycle after the CSUM byte's rx_valid when the FIFO was empty.
  - cmd_* are driven from FIFO storage at the read pointer. They are stable while cmd_valid & !cmd_ready.
- Pop: on cmd_valid & cmd_ready. Both pointers wrap modulo FIFO_DEPTH.
- Full FIFO:
  - Push while full with no pop in the same cycle -> frame dropped, err_ovf pulses, contents unchanged.
  - Push while full with a pop in the same cycle -> push accepted, count unchanged.
- Empty FIFO: cmd_ready is ignored, no underflow.
- err_total increments on each err_* pulse and saturates at 255. Only one error can pulse per cycle.
- The parser itself applies no backpressure. rx_valid bytes are never stalled.

Optional Feature:
- Macro: UART_CMD_FRAME_PARSER_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_valid and runs while the FSM is not in HUNT.
  - On reaching TIMEOUT_CYC-1 with no byte: FSM -> HUNT, err_timeout pulses, partial frame discarded.
  - If rx_valid arrives in the same cycle, the byte wins and no timeout occurs.
- Undefined: no counter is present, err_timeout is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Package uart_cmd_pkg holds:
  - SYNC_BYTE default
  - FSM state encoding
  - ALU opcode constants (3-bit, shared with ALU/SWITCH)
  - frame-field bit positions
- One sub-module: cmd_fifo. It is a synchronous FIFO parametrised by width and depth, with push/pop/full/empty/count and simultaneous push+pop on full. The parser stores packed {opcode, ch, a, b} in it.

Test Plan:
- Normal frame, DATA_W=8, CH_W=2: bytes 00 FF A5 0B 12 34 2D, cmd_ready=0 -> one cycle after 2D, cmd_valid=1, opcode=3, ch=1, a=0x12, b=0x34, cmd_count=1. The leading 00 FF are ignored.
- Bad checksum: A5 0B 12 34 2C -> err_csum pulses one cycle, cmd_valid stays 0, err_total=1.
- Wide operands, DATA_W=16: A5 02 12 34 56 78 0A -> opcode=2, ch=0, a=0x1234, b=0x5678.
- Overflow, FIFO_DEPTH=4, cmd_ready=0: five valid frames -> cmd_count=4, err_ovf on the fifth. Then cmd_ready=1 pops frames 1..4 in order, and cmd_valid drops after four pops. Separately, push+pop in the same cycle while full -> no err_ovf.
- Timeout (macro defined, TIMEOUT_CYC=100): A5 0B then 100 idle cycles -> err_timeout, FSM in HUNT. The next full frame is accepted correctly. With the macro undefined, no error occurs and the frame completes when the bytes resume.
- Reset mid-frame: assert rst_n=0 after A5 0B 12, then release, then send a full valid frame -> exactly one command with the new values, no error pulses.
